picorv32_trace_buffer: RTL and testbench

//   Trigger-based trace capture downstream of picorv32_demo_system trace port (trace_valid/trace_data).

---
 rtl/picorv32_trace_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_picorv32_trace_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_trace_buffer.sv
// ---------------------------------------------------------------------------
// picorv32_trace_buffer
//
// Trigger-based capture of the picorv32 trace stream. While armed, every
// trace word is written into a circular RAM. A trap is the trigger. After it,
// POST_TRIG more words are captured and the window is frozen. The frozen
// window is then replayed oldest-first over a valid/ready stream.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   trace_valid_i  trace word strobe
//   trace_data_i   36-bit trace word
//   trap_i         trigger (only looked at while ARMED)
//   arm_i          start a new capture (only looked at while IDLE)
//   rd_valid_o     readout word valid
//   rd_ready_i     readout consumer ready
//   rd_data_o      readout word
//   rd_last_o      final word of the window (qualified by rd_valid_o)
//   state_o        0 IDLE, 1 ARMED, 2 POST, 3 DUMP
//   count_o        words held, saturates at 2**DEPTH_LOG2
//   overflow_o     sticky: the oldest words were overwritten
// ---------------------------------------------------------------------------
module picorv32_trace_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int POST_TRIG  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trace_valid_i,
  input  logic [35:0]           trace_data_i,
  input  logic                  trap_i,
  input  logic                  arm_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [35:0]           rd_data_o,
  output logic                  rd_last_o,
  output logic [1:0]            state_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL      = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam int                    POST_LAST_I = (POST_TRIG > 0) ? POST_TRIG - 1 : 0;
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0]     count_reg, count_next;
  logic                    overflow_reg, overflow_next;
  logic [DEPTH_LOG2-1:0]   post_cnt_reg, post_cnt_next;
  logic [DEPTH_LOG2-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]     fetch_left_reg, fetch_left_next;
  logic                    primed_reg, primed_next;
  logic                    valid_reg, valid_next;
  logic                    last_reg, last_next;
  logic [35:0]             rd_data_reg;

  logic                    capture_we;
  logic                    xfer;
  logic                    fetch;

  logic [35:0]             mem [DEPTH];

  assign capture_we = trace_valid_i && ((state_reg == ST_ARMED) || (state_reg == ST_POST));
  assign xfer       = valid_reg && rd_ready_i;
  // The RAM read register doubles as the output register: it is refilled
  // whenever it is empty or its word is leaving this cycle, which gives one
  // word per cycle while the consumer keeps ready high.
  assign fetch      = (state_reg == ST_DUMP) && primed_reg && (fetch_left_reg != '0)
                      && (!valid_reg || rd_ready_i);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arm_i) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (trap_i) state_next = (POST_TRIG == 0) ? ST_DUMP : ST_POST;
      end
      ST_POST: begin
        if (capture_we && (post_cnt_reg == POST_LAST)) state_next = ST_DUMP;
      end
      ST_DUMP: begin
        // Empty window leaves after the setup cycle; otherwise leave when
        // the last word is accepted.
        if ((!primed_reg && (count_reg == '0)) || (xfer && last_reg)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_o    = state_reg;
    rd_valid_o = valid_reg;
    rd_last_o  = valid_reg && last_reg;
    rd_data_o  = rd_data_reg;
    count_o    = count_reg;
    overflow_o = overflow_reg;
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    count_next      = count_reg;
    overflow_next   = overflow_reg;
    post_cnt_next   = post_cnt_reg;
    rd_ptr_next     = rd_ptr_reg;
    fetch_left_next = fetch_left_reg;
    primed_next     = primed_reg;
    valid_next      = valid_reg;
    last_next       = last_reg;

    if ((state_reg == ST_IDLE) && arm_i) begin
      wr_ptr_next   = '0;
      count_next    = '0;
      overflow_next = 1'b0;
      post_cnt_next = '0;
    end

    if (capture_we) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (count_reg == FULL) begin
        overflow_next = 1'b1;
      end else begin
        count_next = count_reg + CNT_ONE;
      end
      // The trigger-cycle word is written from ARMED, so it is not counted.
      if (state_reg == ST_POST) post_cnt_next = post_cnt_reg + PTR_ONE;
    end

    // First DUMP cycle: locate the oldest word. With a full buffer the low
    // bits of count are zero and the oldest word sits at wr_ptr itself.
    if ((state_reg == ST_DUMP) && !primed_reg) begin
      rd_ptr_next     = wr_ptr_reg - count_reg[DEPTH_LOG2-1:0];
      fetch_left_next = count_reg;
      primed_next     = 1'b1;
    end

    if (xfer) valid_next = 1'b0;

    if (fetch) begin
      rd_ptr_next     = rd_ptr_reg + PTR_ONE;
      fetch_left_next = fetch_left_reg - CNT_ONE;
      valid_next      = 1'b1;
      last_next       = (fetch_left_reg == CNT_ONE);
    end

    if ((state_reg == ST_DUMP) && (state_next == ST_IDLE)) primed_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      post_cnt_reg   <= '0;
      rd_ptr_reg     <= '0;
      fetch_left_reg <= '0;
      primed_reg     <= 1'b0;
      valid_reg      <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      overflow_reg   <= overflow_next;
      post_cnt_reg   <= post_cnt_next;
      rd_ptr_reg     <= rd_ptr_next;
      fetch_left_reg <= fetch_left_next;
      primed_reg     <= primed_next;
      valid_reg      <= valid_next;
      last_reg       <= last_next;
    end
  end

  // -------------------------------------------------------------------------
  // Trace RAM: write port in capture states, registered read port in DUMP.
  // Contents are deliberately not cleared by reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (capture_we) mem[wr_ptr_reg] <= trace_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_reg <= '0;
    end else if (fetch) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

endmodule

// File: tb/tb_picorv32_trace_buffer.sv
// ---------------------------------------------------------------------------
// Bench for picorv32_trace_buffer. Two instances share the clock:
//   index 0: DEPTH_LOG2=10, POST_TRIG=2
//   index 1: DEPTH_LOG2=3,  POST_TRIG=0
// The expected window is kept as a queue of captured words trimmed to the
// buffer depth; the readout is compared word by word against that queue.
// ---------------------------------------------------------------------------
module tb_picorv32_trace_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic [1:0]        tv;
  logic [1:0][35:0]  td;
  logic [1:0]        trap;
  logic [1:0]        arm;
  logic [1:0]        rdy;
  logic [1:0]        rv;
  logic [1:0][35:0]  rd;
  logic [1:0]        rl;
  logic [1:0][1:0]   st;
  logic [1:0]        ovf;
  logic [10:0]       cnt_a;
  logic [3:0]        cnt_b;

  picorv32_trace_buffer #(.DEPTH_LOG2(10), .POST_TRIG(2)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .trace_valid_i(tv[0]), .trace_data_i(td[0]),
    .trap_i(trap[0]), .arm_i(arm[0]), .rd_valid_o(rv[0]), .rd_ready_i(rdy[0]),
    .rd_data_o(rd[0]), .rd_last_o(rl[0]), .state_o(st[0]), .count_o(cnt_a),
    .overflow_o(ovf[0])
  );

  picorv32_trace_buffer #(.DEPTH_LOG2(3), .POST_TRIG(0)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .trace_valid_i(tv[1]), .trace_data_i(td[1]),
    .trap_i(trap[1]), .arm_i(arm[1]), .rd_valid_o(rv[1]), .rd_ready_i(rdy[1]),
    .rd_data_o(rd[1]), .rd_last_o(rl[1]), .state_o(st[1]), .count_o(cnt_b),
    .overflow_o(ovf[1])
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [35:0] mq[$];
  bit          m_ovf;
  logic [35:0] seq;

  function automatic int depth_of(input int s);
    return (s == 1) ? 8 : 1024;
  endfunction

  function automatic int pt_of(input int s);
    return (s == 1) ? 0 : 2;
  endfunction

  function automatic logic [10:0] cnt_of(input int s);
    return (s == 1) ? {7'd0, cnt_b} : cnt_a;
  endfunction

  function automatic logic [35:0] rand36();
    logic [3:0] h;
    h = 4'($urandom_range(0, 15));
    return {h, $urandom()};
  endfunction

  function automatic bit ready_pat(input int k);
    return ((k % 4) == 0) || ((k % 4) == 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: the window is the most recent depth words captured.
  task automatic mpush(input int s, input logic [35:0] d);
    mq.push_back(d);
    if (mq.size() > depth_of(s)) begin
      void'(mq.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset(input int s);
    rst[s] = 1'b1;
    tv[s] = 1'b0; trap[s] = 1'b0; arm[s] = 1'b0; rdy[s] = 1'b0;
    step();
    step();
    chk("rst_state", st[s], 0);
    chk("rst_valid", rv[s], 0);
    chk("rst_last", rl[s], 0);
    chk("rst_data", rd[s], 0);
    chk("rst_count", cnt_of(s), 0);
    chk("rst_ovf", ovf[s], 0);
    rst[s] = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // Arm, capture n_pre words, trigger, then capture the post-trigger words.
  // Returns at the first observed DUMP cycle with a junk word on the input.
  task automatic capture(input int s, input int n_pre, input bit trap_v, input int gap,
                         input bit noise, input bit hold, input bit rnd);
    logic [35:0] d;
    bit v;
    int w;
    int p;
    mq.delete();
    m_ovf = 1'b0;
    arm[s] = 1'b1;
    step();
    arm[s] = 1'b0;
    chk("arm_state", st[s], 1);
    chk("arm_count", cnt_of(s), 0);
    chk("arm_ovf", ovf[s], 0);
    w = 0;
    while (w < n_pre) begin
      v = ($urandom_range(0, 99) >= gap);
      d = rnd ? rand36() : seq;
      tv[s] = v; td[s] = d;
      arm[s] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      if (v) begin
        mpush(s, d);
        w++;
        if (!rnd) seq = seq + 1;
      end
      chk("armed_state", st[s], 1);
      chk("armed_count", cnt_of(s), mq.size());
    end
    d = rnd ? rand36() : seq;
    tv[s] = trap_v; td[s] = d; trap[s] = 1'b1; arm[s] = 1'b0;
    step();
    if (trap_v) begin
      mpush(s, d);
      if (!rnd) seq = seq + 1;
    end
    trap[s] = hold;
    p = 0;
    while (p < pt_of(s)) begin
      chk("post_state", st[s], 2);
      chk("post_count", cnt_of(s), mq.size());
      v = ($urandom_range(0, 99) >= gap);
      d = rnd ? rand36() : seq;
      tv[s] = v; td[s] = d;
      if (noise) trap[s] = hold | 1'($urandom_range(0, 1));
      step();
      if (v) begin
        mpush(s, d);
        p++;
        if (!rnd) seq = seq + 1;
      end
    end
    chk("entry_state", st[s], 3);
    chk("entry_count", cnt_of(s), mq.size());
    chk("entry_ovf", ovf[s], m_ovf);
    trap[s] = 1'b0;
    tv[s] = 1'b1;
    td[s] = rand36();
  endtask

  // Drain the window. mode 0: always ready, 1: ready 1,0,0,1, 2: random.
  // stop_after >= 0 returns after that many transfers (readout still live).
  task automatic dump(input int s, input int mode, input int stop_after);
    int idx, cyc, k, limit;
    bit holding, held_last, r, done, seen;
    logic [35:0] held;
    idx = 0; cyc = 0; k = 0; holding = 0; held_last = 0; done = 0; seen = 0;
    held = '0;
    limit = 8 * mq.size() + 40;
    if (mq.size() == 0) begin
      chk("empty_valid0", rv[s], 0);
      tv[s] = 1'b0;
      step();
      chk("empty_state", st[s], 0);
      chk("empty_valid1", rv[s], 0);
      chk("empty_count", cnt_of(s), 0);
      step();
      chk("empty_valid2", rv[s], 0);
      return;
    end
    while (!done && cyc < limit) begin
      if (stop_after >= 0 && idx == stop_after) break;
      r = 1'b0;
      if (rv[s]) begin
        if (!seen) begin
          chk("dump_latency", cyc, 2);
          seen = 1;
        end
        if (holding) begin
          chk("hold_data", rd[s], held);
          chk("hold_last", rl[s], held_last);
        end
        case (mode)
          0: r = 1'b1;
          1: r = ready_pat(k);
          default: r = 1'($urandom_range(0, 1));
        endcase
        k++;
        if (r) begin
          chk("dump_data", rd[s], mq[idx]);
          chk("dump_last", rl[s], (idx == mq.size() - 1));
          if (idx == mq.size() - 1) done = 1;
          idx++;
          holding = 0;
        end else begin
          holding = 1;
          held = rd[s];
          held_last = rl[s];
        end
      end else begin
        if (holding) begin
          chk("hold_valid", rv[s], 1);
          holding = 0;
        end
        r = 1'($urandom_range(0, 1));
      end
      rdy[s] = r;
      tv[s] = 1'($urandom_range(0, 1));
      td[s] = rand36();
      trap[s] = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    rdy[s] = 1'b0; tv[s] = 1'b0; trap[s] = 1'b0;
    if (stop_after < 0) begin
      chk("dump_done", done, 1);
      chk("after_valid", rv[s], 0);
      chk("after_state", st[s], 0);
      chk("after_count", cnt_of(s), mq.size());
      chk("after_ovf", ovf[s], m_ovf);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11; tv = '0; td = '0; trap = '0; arm = '0; rdy = '0;
    seq = '0; m_ovf = 1'b0;

    do_reset(0);
    do_reset(1);

    // Basic: words 1..5, trap, post words 6,7
    seq = 36'h1;
    capture(0, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    dump(0, 0, -1);

    // Trap and words in IDLE do nothing
    trap[0] = 1'b1; tv[0] = 1'b1; td[0] = rand36();
    step();
    step();
    chk("idle_trap_state", st[0], 0);
    chk("idle_trap_count", cnt_of(0), 7);
    trap[0] = 1'b0; tv[0] = 1'b0;

    // Trap held through POST, backpressure 1,0,0,1
    seq = 36'h100;
    capture(0, 6, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    dump(0, 1, -1);

    // arm toggling while ARMED, gaps, random data, random ready
    capture(0, 9, 1'b1, 30, 1'b1, 1'b1, 1'b1);
    dump(0, 2, -1);

    // Wrap on the small instance: 12 words into 8 entries
    seq = 36'h0;
    capture(1, 12, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    dump(1, 0, -1);

    // Empty window
    capture(1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    dump(1, 0, -1);

    // Reset after 2 of 7 words, then re-arm
    seq = 36'h1;
    capture(0, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    dump(0, 0, 2);
    rst[0] = 1'b1;
    step();
    chk("midrst_state", st[0], 0);
    chk("midrst_valid", rv[0], 0);
    chk("midrst_count", cnt_of(0), 0);
    chk("midrst_ovf", ovf[0], 0);
    rst[0] = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    seq = 36'h50;
    capture(0, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    dump(0, 0, -1);

    // Randomized windows on both instances
    for (int i = 0; i < 6; i++) begin
      capture(0, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 25, 1'b1,
              1'($urandom_range(0, 1)), 1'b1);
      dump(0, 2, -1);
    end
    for (int i = 0; i < 6; i++) begin
      capture(1, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 25, 1'b1,
              1'b0, 1'b1);
      dump(1, 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
